draw_sequencer: RTL and testbench
=================================

Name: draw_sequencer

Overview:
Top-level drawing controller that sits between the pixel generators (screen-clear stage and shape stage, e.g. circle/reuleaux) and the VGA adapter's plot interface. On one start request it runs a full-screen clear, then the shape draw. It muxes the active generator's pixel stream onto a single registered, clipped plot port. It is the only block driving the VGA adapter's x/y/colour/plot inputs.

Parameters:
SCREEN_W, 160, visible width in pixels; plots with x >= SCREEN_W are suppressed.
SCREEN_H, 120, visible height in pixels; plots with y >= SCREEN_H are suppressed.
CLEAR_COLOUR, 3'b000, colour driven to the clear stage.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level request; held high for the whole operation
done  out  1  high from completion until start drops
colour  in  3  shape colour, sampled on the start edge
centre_x  in  8  shape centre x, sampled on the start edge
centre_y  in  7  shape centre y, sampled on the start edge
diameter  in  8  shape size, sampled on the start edge
fill_start  out  1  start to clear stage
fill_colour  out  3  colour to clear stage (= CLEAR_COLOUR)
fill_done  in  1  clear stage done
fill_x / fill_y / fill_col / fill_plot  in  8/7/3/1  clear stage pixel stream
shape_start  out  1  start to shape stage
shape_colour / shape_cx / shape_cy / shape_diam  out  3/8/7/8  latched shape parameters
shape_done  in  1  shape stage done
shape_x / shape_y / shape_col / shape_plot  in  8/7/3/1  shape stage pixel stream
vga_x / vga_y / vga_colour / vga_plot  out  8/7/3/1  to VGA adapter

Behaviour:
- Reset (async, rst_n=0): state IDLE. done, fill_start, shape_start, vga_plot = 0. vga_x, vga_y, vga_colour = 0. Latched parameters = 0.
- States: IDLE, FILL, DRAW, DONE. All transitions occur on the clk edge.
- IDLE: when start=1, latch colour/centre_x/centre_y/diameter and go to FILL. fill_start=1 from the next cycle.
- FILL: fill_start=1. When fill_done=1, go to DRAW. fill_start=0 and shape_start=1 from the next cycle.
- DRAW: shape_start=1. When shape_done=1, go to DONE. shape_start=0 and done=1 from the next cycle.
- DONE: done=1 while start=1. When start=0, go to IDLE; done=0 next cycle.
- Abort: start=0 in FILL or DRAW goes to IDLE next cycle. Both sub-starts drop and vga_plot=0 from that cycle. done is never asserted on abort.
- Pixel mux: in FILL select the fill_* stream; in DRAW select the shape_* stream; in IDLE or DONE, plot=0.
- A source plot is accepted only when that source's done=0.
- Output register: vga_* = selected stream delayed by exactly 1 cycle.
- vga_plot(t+1) = sel_plot(t) & (sel_x < SCREEN_W) & (sel_y < SCREEN_H). Compare at full port width, with no wrap or truncation.
- vga_x/vga_y/vga_colour update every cycle from the selected stream even when plot is suppressed. They hold their value in IDLE/DONE.
- Same-cycle source done with plot=1: that pixel is dropped. The generators deassert plot on their done cycle, so no pixel is lost.
- Restart: start low then high re-latches parameters and reruns FILL then DRAW. There is no minimum idle time beyond one IDLE cycle.
- Parameter inputs are ignored after the start edge; changes mid-operation have no effect.

Test Plan:
- Reset mid-DRAW (rst_n pulse) -> same cycle: vga_plot=0, done=0, fill_start=0, shape_start=0; state IDLE.
- Normal run: start=1, colour=3'b010, centre=(80,60), diameter=80 -> fill_start high 1 cycle later. After the fill stub pulses fill_done, shape_start rises next cycle with shape_colour=3'b010, shape_cx=80, shape_cy=60. After shape_done, done=1 until start=0, then done=0 next cycle.
- Latency/mux: fill stub drives (5,7,3'b000,plot=1) at cycle t in FILL -> vga_x=5, vga_y=7, vga_colour=0, vga_plot=1 at t+1. Shape stream values during FILL never appear on vga_*.
- Clipping in DRAW: shape drives (159,119,plot=1) -> vga_plot=1. Shape drives (160,10), (200,119), (20,120) and (0,127) -> vga_plot=0 for each.
- Abort: start dropped 3 cycles into DRAW -> next cycle shape_start=0, vga_plot=0, done stays 0. Re-raising start with colour=3'b111 -> new FILL, then shape_colour=3'b111.
- Done-cycle drop: fill stub asserts fill_done and fill_plot together -> no vga_plot for that pixel; next selected stream is shape.

Source files
------------

// File: rtl/draw_sequencer.sv
// Drawing controller: one start request runs a full-screen clear, then a shape draw,
// and forwards the active generator's pixels to the VGA adapter through one clipped register.
module draw_sequencer #(
  parameter int unsigned SCREEN_W     = 160,
  parameter int unsigned SCREEN_H     = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       done,
  input  logic [2:0] colour,
  input  logic [7:0] centre_x,
  input  logic [6:0] centre_y,
  input  logic [7:0] diameter,
  output logic       fill_start,
  output logic [2:0] fill_colour,
  input  logic       fill_done,
  input  logic [7:0] fill_x,
  input  logic [6:0] fill_y,
  input  logic [2:0] fill_col,
  input  logic       fill_plot,
  output logic       shape_start,
  output logic [2:0] shape_colour,
  output logic [7:0] shape_cx,
  output logic [6:0] shape_cy,
  output logic [7:0] shape_diam,
  input  logic       shape_done,
  input  logic [7:0] shape_x,
  input  logic [6:0] shape_y,
  input  logic [2:0] shape_col,
  input  logic       shape_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Handshake: start is a level held for the whole run; the sub-stage starts are levels
  // held while that stage owns the screen, each stage answers with a done level, and our
  // done stays high until start drops. Dropping start early aborts back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_FILL;
      S_FILL: begin
        if (!start)         state_nxt = S_IDLE;
        else if (fill_done) state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if (!start)          state_nxt = S_IDLE;
        else if (shape_done) state_nxt = S_DONE;
      end
      S_DONE: if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fill_start  = (state == S_FILL);
    shape_start = (state == S_DRAW);
    done        = (state == S_DONE);
    fill_colour = CLEAR_COLOUR;
    dbg_state   = state;
  end

  // Shape parameters are captured only on the idle->fill transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shape_colour <= 3'd0;
      shape_cx     <= 8'd0;
      shape_cy     <= 7'd0;
      shape_diam   <= 8'd0;
    end else if (state == S_IDLE && start) begin
      shape_colour <= colour;
      shape_cx     <= centre_x;
      shape_cy     <= centre_y;
      shape_diam   <= diameter;
    end
  end

  logic       sel_valid;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_col;
  logic       sel_plot;
  logic       sel_visible;

  // A pixel on a source's done cycle, or on an abort cycle, is not forwarded.
  always_comb begin
    sel_valid = 1'b0;
    sel_x     = 8'd0;
    sel_y     = 7'd0;
    sel_col   = 3'd0;
    sel_plot  = 1'b0;
    case (state)
      S_FILL: begin
        sel_valid = 1'b1;
        sel_x     = fill_x;
        sel_y     = fill_y;
        sel_col   = fill_col;
        sel_plot  = fill_plot & ~fill_done & start;
      end
      S_DRAW: begin
        sel_valid = 1'b1;
        sel_x     = shape_x;
        sel_y     = shape_y;
        sel_col   = shape_col;
        sel_plot  = shape_plot & ~shape_done & start;
      end
      default: ;
    endcase
  end

  assign sel_visible = ({24'd0, sel_x} < SCREEN_W) && ({25'd0, sel_y} < SCREEN_H);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      if (sel_valid) begin
        vga_x      <= sel_x;
        vga_y      <= sel_y;
        vga_colour <= sel_col;
      end
      vga_plot <= sel_plot & sel_visible;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: directed literal checks plus randomized generator streams
// compared every cycle against a phase-level reference model.
module tb_draw_sequencer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int P_IDLE = 0, P_FILL = 1, P_DRAW = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       done;
  logic [2:0] colour;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [7:0] diameter;
  logic       fill_start;
  logic [2:0] fill_colour;
  logic       fill_done;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic [2:0] fill_col;
  logic       fill_plot;
  logic       shape_start;
  logic [2:0] shape_colour;
  logic [7:0] shape_cx;
  logic [6:0] shape_cy;
  logic [7:0] shape_diam;
  logic       shape_done;
  logic [7:0] shape_x;
  logic [6:0] shape_y;
  logic [2:0] shape_col;
  logic       shape_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  draw_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done),
    .colour(colour), .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
    .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
    .fill_x(fill_x), .fill_y(fill_y), .fill_col(fill_col), .fill_plot(fill_plot),
    .shape_start(shape_start), .shape_colour(shape_colour), .shape_cx(shape_cx),
    .shape_cy(shape_cy), .shape_diam(shape_diam), .shape_done(shape_done),
    .shape_x(shape_x), .shape_y(shape_y), .shape_col(shape_col), .shape_plot(shape_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: start low always returns to idle; otherwise each phase advances on its done
  int         m_phase;
  logic [2:0] m_col;
  logic [7:0] m_cx;
  logic [6:0] m_cy;
  logic [7:0] m_diam;
  logic [7:0] m_vx;
  logic [6:0] m_vy;
  logic [2:0] m_vc;
  logic       m_vp;

  function automatic bit visible(input int x, input int y);
    return (x < W) && (y < H);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= P_IDLE;
      m_col <= '0; m_cx <= '0; m_cy <= '0; m_diam <= '0;
      m_vx <= '0; m_vy <= '0; m_vc <= '0; m_vp <= 1'b0;
    end else begin
      if (m_phase == P_FILL) begin
        m_vx <= fill_x; m_vy <= fill_y; m_vc <= fill_col;
        m_vp <= start && fill_plot && !fill_done && visible(int'(fill_x), int'(fill_y));
      end else if (m_phase == P_DRAW) begin
        m_vx <= shape_x; m_vy <= shape_y; m_vc <= shape_col;
        m_vp <= start && shape_plot && !shape_done && visible(int'(shape_x), int'(shape_y));
      end else begin
        m_vp <= 1'b0;
      end
      if (m_phase == P_IDLE && start) begin
        m_phase <= P_FILL;
        m_col <= colour; m_cx <= centre_x; m_cy <= centre_y; m_diam <= diameter;
      end else if (!start)                      m_phase <= P_IDLE;
      else if (m_phase == P_FILL && fill_done)  m_phase <= P_DRAW;
      else if (m_phase == P_DRAW && shape_done) m_phase <= P_DONE;
    end
  end

  // scoreboard: every cycle, away from the active edge
  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      chk("state", int'(dbg_state), m_phase);
      chk("fill_start", int'(fill_start), int'(m_phase == P_FILL));
      chk("shape_start", int'(shape_start), int'(m_phase == P_DRAW));
      chk("done", int'(done), int'(m_phase == P_DONE));
      chk("fill_colour", int'(fill_colour), 0);
      chk("shape_colour", int'(shape_colour), int'(m_col));
      chk("shape_cx", int'(shape_cx), int'(m_cx));
      chk("shape_cy", int'(shape_cy), int'(m_cy));
      chk("shape_diam", int'(shape_diam), int'(m_diam));
      chk("vga_plot", int'(vga_plot), int'(m_vp));
      chk("vga_x", int'(vga_x), int'(m_vx));
      chk("vga_y", int'(vga_y), int'(m_vy));
      chk("vga_colour", int'(vga_colour), int'(m_vc));
    end
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_fill(input int x, input int y, input int c, input bit p, input bit d);
    fill_x = 8'(x); fill_y = 7'(y); fill_col = 3'(c); fill_plot = p; fill_done = d;
  endtask

  task automatic set_shape(input int x, input int y, input int c, input bit p, input bit d);
    shape_x = 8'(x); shape_y = 7'(y); shape_col = 3'(c); shape_plot = p; shape_done = d;
  endtask

  task automatic begin_run(input int c);
    start = 1'b1; colour = 3'(c); centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd80;
  endtask

  int clip_x[4] = '{160, 200, 20, 0};
  int clip_y[4] = '{10, 119, 120, 127};

  initial begin
    rst_n = 1'b0;
    start = 1'b0; colour = '0; centre_x = '0; centre_y = '0; diameter = '0;
    set_fill(0, 0, 0, 1'b0, 1'b0);
    set_shape(0, 0, 0, 1'b0, 1'b0);
    check_en = 1'b1;
    step();
    chk("rst_state", int'(dbg_state), P_IDLE);
    chk("rst_vga_plot", int'(vga_plot), 0);
    chk("rst_shape_colour", int'(shape_colour), 0);
    rst_n = 1'b1;
    step();

    // normal run with mux latency, done-cycle drop and clipping
    begin_run(3'b010);
    step();
    chk("run_fill_start", int'(fill_start), 1);
    colour = 3'b101; centre_x = 8'd3;
    set_fill(5, 7, 0, 1'b1, 1'b0);
    set_shape(99, 99, 7, 1'b1, 1'b0);
    step();
    chk("lat_vga_x", int'(vga_x), 5);
    chk("lat_vga_y", int'(vga_y), 7);
    chk("lat_vga_colour", int'(vga_colour), 0);
    chk("lat_vga_plot", int'(vga_plot), 1);
    set_fill(9, 9, 0, 1'b1, 1'b1);
    step();
    chk("dropcycle_vga_plot", int'(vga_plot), 0);
    chk("draw_shape_start", int'(shape_start), 1);
    chk("draw_fill_start", int'(fill_start), 0);
    chk("draw_shape_colour", int'(shape_colour), 2);
    chk("draw_shape_cx", int'(shape_cx), 80);
    chk("draw_shape_cy", int'(shape_cy), 60);
    set_fill(0, 0, 0, 1'b0, 1'b0);
    set_shape(159, 119, 6, 1'b1, 1'b0);
    step();
    chk("clip_corner_plot", int'(vga_plot), 1);
    chk("clip_corner_x", int'(vga_x), 159);
    for (int i = 0; i < 4; i++) begin
      set_shape(clip_x[i], clip_y[i], 6, 1'b1, 1'b0);
      step();
      chk($sformatf("clip_%0d_%0d", clip_x[i], clip_y[i]), int'(vga_plot), 0);
    end
    set_shape(0, 0, 0, 1'b0, 1'b1);
    step();
    chk("done_rise", int'(done), 1);
    chk("done_shape_start", int'(shape_start), 0);
    set_shape(0, 0, 0, 1'b0, 1'b0);
    step();
    chk("done_hold", int'(done), 1);
    start = 1'b0;
    step();
    chk("done_fall", int'(done), 0);

    // abort three cycles into draw, then restart with a new colour
    begin_run(3'b011);
    step();
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    set_shape(10, 10, 3, 1'b1, 1'b0);
    step(); step(); step();
    start = 1'b0;
    step();
    chk("abort_shape_start", int'(shape_start), 0);
    chk("abort_vga_plot", int'(vga_plot), 0);
    chk("abort_done", int'(done), 0);
    begin_run(3'b111);
    step();
    chk("restart_fill_start", int'(fill_start), 1);
    fill_done = 1'b1;
    step();
    fill_done = 1'b0;
    chk("restart_shape_colour", int'(shape_colour), 7);
    chk("restart_shape_start", int'(shape_start), 1);

    // asynchronous reset in the middle of draw
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_vga_plot", int'(vga_plot), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_fill_start", int'(fill_start), 0);
    chk("midrst_shape_start", int'(shape_start), 0);
    chk("midrst_state", int'(dbg_state), P_IDLE);
    start = 1'b0;
    set_shape(0, 0, 0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // randomized generator streams
    for (int n = 0; n < 3000; n++) begin
      if (start) start = ($urandom_range(0, 39) != 0);
      else       start = ($urandom_range(0, 2) == 0);
      colour   = 3'($urandom_range(0, 7));
      centre_x = 8'($urandom_range(0, 255));
      centre_y = 7'($urandom_range(0, 127));
      diameter = 8'($urandom_range(0, 255));
      set_fill($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0);
      set_shape($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0);
      step();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
